// File: rtl/wb_dtlb.sv
// Data-side TLB stage between the lm32 dbus master and the arbiter: direct-mapped translation,
// miss signalled as a Wishbone error, plus a locally decoded control window.
module wb_dtlb #(
  parameter int unsigned ENTRIES   = 8,
  parameter int unsigned PAGE_BITS = 12,
  parameter logic [3:0]  CTRL_ADR  = 4'hE
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [29:0] m_adr_i,
  input  logic [31:0] m_dat_i,
  output logic [31:0] m_dat_o,
  input  logic [3:0]  m_sel_i,
  input  logic        m_cyc_i,
  input  logic        m_stb_i,
  input  logic        m_we_i,
  output logic        m_ack_o,
  output logic        m_err_o,
  output logic [29:0] s_adr_o,
  output logic [31:0] s_dat_o,
  output logic [3:0]  s_sel_o,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  output logic [2:0]  s_cti_o,
  output logic [1:0]  s_bte_o,
  input  logic [31:0] s_dat_i,
  input  logic        s_ack_i,
  input  logic        s_err_i,
  output logic        miss_o
);
  localparam int unsigned IDX   = $clog2(ENTRIES);
  localparam int unsigned OFS   = PAGE_BITS - 2;
  localparam int unsigned TAG_W = 30 - OFS - IDX;
  localparam int unsigned PPN_W = 32 - PAGE_BITS;

  typedef enum logic [1:0] {StIdle, StLookup, StFwd} state_e;
  state_e state_q, state_d;

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q [ENTRIES];
  logic [PPN_W-1:0]   ppn_q [ENTRIES];

  logic        enable_q, enable_d, sticky_q, sticky_d, ctrl_ack_q;
  logic [31:0] vaddr_q, vaddr_d, missadr_q, missadr_d, ctrl_rdata_q, ctrl_rdata_d;
  logic [29:0] phys_q, phys_d;
  logic        fill, inval, lookup_miss;

  logic req, is_ctrl, ctrl_req, ctrl_wr, fwd, hit;
  logic [IDX-1:0]   lk_idx, fill_idx;
  logic [TAG_W-1:0] lk_tag;

  assign req      = m_cyc_i & m_stb_i;
  assign is_ctrl  = (m_adr_i[29:26] == CTRL_ADR);
  // Control accesses are only taken while idle, and never back-to-back with their own ack.
  assign ctrl_req = req & is_ctrl & (state_q == StIdle) & ~ctrl_ack_q;
  assign ctrl_wr  = ctrl_req & m_we_i & (m_sel_i == 4'hF);
  assign fwd      = (state_q == StFwd);

  assign lk_idx   = m_adr_i[OFS +: IDX];
  assign lk_tag   = m_adr_i[29 -: TAG_W];
  assign hit      = valid_q[lk_idx] & (tag_q[lk_idx] == lk_tag);
  assign fill_idx = vaddr_q[PAGE_BITS +: IDX];

  always_comb begin
    state_d     = state_q;
    phys_d      = phys_q;
    lookup_miss = 1'b0;
    case (state_q)
      StIdle: if (req && !is_ctrl) state_d = StLookup;
      StLookup: begin
        if (!m_cyc_i) begin
          state_d = StIdle;
        end else if (!enable_q) begin
          phys_d  = m_adr_i;
          state_d = StFwd;
        end else if (hit) begin
          phys_d  = {ppn_q[lk_idx], m_adr_i[OFS-1:0]};
          state_d = StFwd;
        end else begin
          lookup_miss = 1'b1;
          state_d     = StIdle;
        end
      end
      StFwd: if (!m_cyc_i || s_ack_i || s_err_i) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    enable_d     = enable_q;
    vaddr_d      = vaddr_q;
    sticky_d     = sticky_q;
    missadr_d    = missadr_q;
    ctrl_rdata_d = '0;
    fill         = 1'b0;
    inval        = 1'b0;
    if (ctrl_req && !m_we_i) begin
      case (m_adr_i[2:0])
        3'd0:    ctrl_rdata_d = {31'b0, enable_q};
        3'd1:    ctrl_rdata_d = vaddr_q;
        3'd4:    ctrl_rdata_d = missadr_q;
        3'd5:    ctrl_rdata_d = {31'b0, sticky_q};
        default: ctrl_rdata_d = '0;
      endcase
    end
    if (ctrl_wr) begin
      case (m_adr_i[2:0])
        3'd0:    enable_d = m_dat_i[0];
        3'd1:    vaddr_d  = m_dat_i;
        3'd2:    fill     = 1'b1;
        3'd3:    inval    = 1'b1;
        3'd5:    if (m_dat_i[0]) sticky_d = 1'b0;
        default: ;
      endcase
    end
    // A miss overrides a simultaneous sticky clear.
    if (lookup_miss) begin
      sticky_d  = 1'b1;
      missadr_d = {m_adr_i, 2'b00};
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q      <= StIdle;
      phys_q       <= '0;
      enable_q     <= 1'b0;
      sticky_q     <= 1'b0;
      vaddr_q      <= '0;
      missadr_q    <= '0;
      ctrl_ack_q   <= 1'b0;
      ctrl_rdata_q <= '0;
      valid_q      <= '0;
    end else begin
      state_q      <= state_d;
      phys_q       <= phys_d;
      enable_q     <= enable_d;
      sticky_q     <= sticky_d;
      vaddr_q      <= vaddr_d;
      missadr_q    <= missadr_d;
      ctrl_ack_q   <= ctrl_req;
      ctrl_rdata_q <= ctrl_rdata_d;
      if (inval)     valid_q           <= '0;
      else if (fill) valid_q[fill_idx] <= m_dat_i[0];
    end
  end

  // Tag/PPN storage is qualified by valid_q, so it needs no reset.
  always_ff @(posedge sys_clk) begin
    if (fill) begin
      tag_q[fill_idx] <= vaddr_q[31 -: TAG_W];
      ppn_q[fill_idx] <= m_dat_i[31:PAGE_BITS];
    end
  end

  assign s_cyc_o = fwd & req;
  assign s_stb_o = fwd & req;
  assign s_we_o  = fwd & m_we_i;
  assign s_sel_o = fwd ? m_sel_i : 4'h0;
  assign s_dat_o = fwd ? m_dat_i : 32'h0;
  assign s_adr_o = phys_q;
  assign s_cti_o = 3'b000;
  assign s_bte_o = 2'b00;

  assign m_ack_o = ctrl_ack_q | (fwd & m_cyc_i & s_ack_i);
  assign m_err_o = lookup_miss | (fwd & m_cyc_i & s_err_i);
  assign m_dat_o = ctrl_ack_q ? ctrl_rdata_q : (fwd ? s_dat_i : 32'h0);
  assign miss_o  = lookup_miss;

endmodule

// File: tb/tb_wb_dtlb.sv
// Scoreboard bench for wb_dtlb: bus transfers push expected responses, the response pops them.
module tb_wb_dtlb;
  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic [29:0] m_adr_i = '0;
  logic [31:0] m_dat_i = '0;
  logic [31:0] m_dat_o;
  logic [3:0]  m_sel_i = '0;
  logic        m_cyc_i = 1'b0, m_stb_i = 1'b0, m_we_i = 1'b0;
  logic        m_ack_o, m_err_o;
  logic [29:0] s_adr_o;
  logic [31:0] s_dat_o;
  logic [3:0]  s_sel_o;
  logic        s_cyc_o, s_stb_o, s_we_o;
  logic [2:0]  s_cti_o;
  logic [1:0]  s_bte_o;
  logic [31:0] s_dat_i;
  logic        s_ack_i, s_err_i;
  logic        miss_o;

  wb_dtlb dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_dat_o(m_dat_o), .m_sel_i(m_sel_i),
    .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i),
    .m_ack_o(m_ack_o), .m_err_o(m_err_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
    .s_cti_o(s_cti_o), .s_bte_o(s_bte_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i),
    .miss_o(miss_o)
  );

  always #5 sys_clk = ~sys_clk;

  // Slave model: acks after slave_wait cycles of strobe; data derived from the address.
  int   slave_wait = 0;
  int   scnt = 0;
  logic slave_auto = 1'b1;
  logic ack_force = 1'b0;
  always @(posedge sys_clk) scnt <= (s_cyc_o && s_stb_o) ? scnt + 1 : 0;
  always_comb begin
    s_ack_i = ack_force | (slave_auto & s_cyc_o & s_stb_o & (scnt == slave_wait));
    s_err_i = 1'b0;
    s_dat_i = {2'b00, s_adr_o} ^ 32'hA5A5_0000;
  end

  function automatic logic [31:0] slave_data(input logic [29:0] adr);
    return {2'b00, adr} ^ 32'hA5A5_0000;
  endfunction

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  typedef struct {
    string       tag;
    logic [2:0]  resp;   // {ack, err, miss}
    logic [31:0] dat;
    logic        chk_sadr;
    logic [29:0] sadr;
    logic        cyc_seen;
    int          lat;
  } exp_t;
  exp_t exp_q[$];

  localparam logic [31:0] CTRL = 32'hE000_0000, VADDR = 32'hE000_0004, PADDR = 32'hE000_0008;
  localparam logic [31:0] INVAL = 32'hE000_000C, MISSADR = 32'hE000_0010, STATUS = 32'hE000_0014;

  task automatic xfer(input string tag, input logic [31:0] badr, input logic we,
                      input logic [31:0] wdat, input logic [3:0] sel, input logic [2:0] resp,
                      input logic [31:0] dat, input logic chk_sadr, input logic [29:0] sadr,
                      input logic cyc_seen, input int lat);
    exp_t e;
    logic [2:0]  g_resp = 3'b000;
    logic [31:0] g_dat = '0;
    logic [29:0] g_sadr = '0;
    logic        g_seen = 1'b0;
    int          g_lat = 0;
    e.tag = tag; e.resp = resp; e.dat = dat; e.chk_sadr = chk_sadr; e.sadr = sadr;
    e.cyc_seen = cyc_seen; e.lat = lat;
    @(posedge sys_clk); #1;
    m_adr_i = badr[31:2]; m_we_i = we; m_dat_i = wdat; m_sel_i = sel;
    m_cyc_i = 1'b1; m_stb_i = 1'b1;
    exp_q.push_back(e);
    while (g_lat < 20) begin
      @(negedge sys_clk);
      g_lat++;
      if (s_cyc_o) g_seen = 1'b1;
      if (m_ack_o || m_err_o) begin
        g_resp = {m_ack_o, m_err_o, miss_o};
        g_dat  = m_dat_o;
        g_sadr = s_adr_o;
        break;
      end
    end
    @(posedge sys_clk); #1;
    m_cyc_i = 1'b0; m_stb_i = 1'b0; m_we_i = 1'b0;
    e = exp_q.pop_front();
    check_eq({e.tag, ".resp"}, {29'b0, g_resp}, {29'b0, e.resp});
    check_eq({e.tag, ".lat"}, 32'(g_lat), 32'(e.lat));
    check_eq({e.tag, ".dat"}, g_dat, e.dat);
    check_eq({e.tag, ".scyc"}, {31'b0, g_seen}, {31'b0, e.cyc_seen});
    if (e.chk_sadr) check_eq({e.tag, ".sadr"}, {2'b00, g_sadr}, {2'b00, e.sadr});
  endtask

  task automatic cwr(input string tag, input logic [31:0] badr, input logic [31:0] wdat);
    xfer(tag, badr, 1'b1, wdat, 4'hF, 3'b100, 32'h0, 1'b0, '0, 1'b0, 2);
  endtask
  task automatic crd(input string tag, input logic [31:0] badr, input logic [31:0] exp);
    xfer(tag, badr, 1'b0, '0, 4'hF, 3'b100, exp, 1'b0, '0, 1'b0, 2);
  endtask
  task automatic trd(input string tag, input logic [31:0] badr, input logic [29:0] phys);
    xfer(tag, badr, 1'b0, '0, 4'hF, 3'b100, slave_data(phys), 1'b1, phys, 1'b1, 3 + slave_wait);
  endtask
  task automatic tmiss(input string tag, input logic [31:0] badr);
    xfer(tag, badr, 1'b0, '0, 4'hF, 3'b011, 32'h0, 1'b0, '0, 1'b0, 2);
  endtask

  task automatic start_fwd(input logic [31:0] badr);
    int n = 0;
    @(posedge sys_clk); #1;
    m_adr_i = badr[31:2]; m_we_i = 1'b0; m_sel_i = 4'hF; m_cyc_i = 1'b1; m_stb_i = 1'b1;
    while (!s_cyc_o && n < 10) begin
      @(negedge sys_clk);
      n++;
    end
  endtask

  initial begin
    repeat (2) @(negedge sys_clk);
    check_eq("rst.ctl", {26'b0, m_ack_o, m_err_o, s_cyc_o, s_stb_o, s_we_o, miss_o}, 32'h0);
    check_eq("rst.sadr", {2'b00, s_adr_o}, 32'h0);
    check_eq("rst.mdat", m_dat_o, 32'h0);
    @(posedge sys_clk); #1 sys_rst_n = 1'b1;

    // Disabled: physical = virtual
    trd("dis_rd", 32'h0000_1234, 30'h48D);
    slave_wait = 2;
    trd("dis_rd_wait", 32'h0000_2008, 30'h802);
    slave_wait = 0;
    crd("ctrl_rst", CTRL, 32'h0);

    // Fill and translate
    cwr("wr_vaddr", VADDR, 32'h0000_3000);
    cwr("wr_paddr", PADDR, 32'h0001_7001);
    cwr("wr_ctrl", CTRL, 32'h1);
    crd("rd_ctrl", CTRL, 32'h1);
    crd("rd_vaddr", VADDR, 32'h0000_3000);
    crd("rd_paddr_wo", PADDR, 32'h0);
    trd("hit_3010", 32'h0000_3010, 30'h5C04);
    slave_wait = 1;
    trd("hit_3ffc", 32'h0000_3FFC, 30'h5FFF);
    slave_wait = 0;
    xfer("partial_wr", CTRL, 1'b1, 32'h0, 4'h3, 3'b100, 32'h0, 1'b0, '0, 1'b0, 2);
    crd("ctrl_kept", CTRL, 32'h1);

    // Miss, status, sticky clear
    tmiss("miss_5000", 32'h0000_5000);
    crd("missadr", MISSADR, 32'h0000_5000);
    crd("status_set", STATUS, 32'h1);
    cwr("status_clr", STATUS, 32'h1);
    crd("status_clr_rd", STATUS, 32'h0);

    // Same index, two tags, then invalidate
    cwr("vaddr0", VADDR, 32'h0000_0000);
    cwr("paddr0", PADDR, 32'h0002_1001);
    trd("idx0_tag0", 32'h0000_0000, 30'h8400);
    cwr("vaddr8", VADDR, 32'h0000_8000);
    cwr("paddr8", PADDR, 32'h0003_3001);
    tmiss("idx0_old", 32'h0000_0000);
    trd("idx0_tag1", 32'h0000_8004, 30'hCC01);
    cwr("inval", INVAL, 32'h0);
    tmiss("inval_8004", 32'h0000_8004);
    tmiss("inval_3010", 32'h0000_3010);

    // Abort during FWD
    cwr("disable", CTRL, 32'h0);
    slave_auto = 1'b0;
    start_fwd(32'h0000_7000);
    check_eq("abort.fwd", {31'b0, s_cyc_o}, 32'h1);
    check_eq("abort.sadr", {2'b00, s_adr_o}, 32'h1C00);
    @(posedge sys_clk); #1;
    m_cyc_i = 1'b0; m_stb_i = 1'b0;
    #1 check_eq("abort.drop", {30'b0, s_cyc_o, s_stb_o}, 32'h0);
    @(posedge sys_clk); #1 ack_force = 1'b1;
    @(negedge sys_clk);
    check_eq("abort.late_ack", {31'b0, m_ack_o}, 32'h0);
    @(posedge sys_clk); #1 ack_force = 1'b0;
    slave_auto = 1'b1;

    // Reset in the middle of FWD
    cwr("rf_vaddr", VADDR, 32'h0000_3000);
    cwr("rf_paddr", PADDR, 32'h0001_7001);
    cwr("rf_ctrl", CTRL, 32'h1);
    slave_auto = 1'b0;
    start_fwd(32'h0000_3010);
    check_eq("rf.fwd", {2'b00, s_adr_o}, 32'h5C04);
    #1 sys_rst_n = 1'b0;
    #1;
    check_eq("rf.ctl", {26'b0, m_ack_o, m_err_o, s_cyc_o, s_stb_o, s_we_o, miss_o}, 32'h0);
    check_eq("rf.sadr", {2'b00, s_adr_o}, 32'h0);
    check_eq("rf.sel", {28'b0, s_sel_o}, 32'h0);
    m_cyc_i = 1'b0; m_stb_i = 1'b0;
    slave_auto = 1'b1;
    repeat (2) @(posedge sys_clk);
    #1 sys_rst_n = 1'b1;
    crd("rf.ctrl0", CTRL, 32'h0);
    trd("rf.dis", 32'h0000_3010, 30'hC04);
    cwr("rf.en", CTRL, 32'h1);
    tmiss("rf.invalid", 32'h0000_3010);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, expected completion");
    $fatal(1);
  end
endmodule
